coef_bank_biquad: RTL and testbench
===================================

Name: coef_bank_biquad

Overview:
- Parametrised, run-time-loadable coefficient bank for cascaded second-order IIR (biquad) sections, in signed fixed point Q10.14.
- Holds five coefficients per section, with a shadow bank for writes and an active bank for reads.
- A handshaked sequencer streams the active coefficients to the shared MAC datapath in a fixed order.
- Shadow-to-active swaps happen only between sweeps, so a sweep never mixes old and new coefficients.

Parameters:
- W, 25, coefficient width in bits, signed, 14 fractional bits.
- NUM_SECT, 2, number of biquad sections (1..8).
- SECT_W, 1, width of section index; must satisfy 2**SECT_W >= NUM_SECT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin one sweep.
- coef_ready  in  1  consumer accepts coef_out this cycle.
- cfg_we  in  1  shadow-bank write strobe.
- cfg_sect  in  SECT_W  section index of the write.
- cfg_idx  in  3  coefficient index of the write (0..4).
- cfg_data  in  W  coefficient value to write.
- swap_req  in  1  single-cycle request to copy shadow into active.
- coef_out  out  W  current coefficient, signed.
- coef_idx  out  3  index of coef_out.
- coef_sect  out  SECT_W  section of coef_out.
- coef_valid  out  1  coef_out/coef_idx/coef_sect are valid.
- coef_last  out  1  marks the final coefficient of the sweep.
- busy  out  1  a sweep is in progress.
- swap_pending  out  1  a swap is requested but not yet applied.
- cfg_err  out  1  one-cycle pulse: the write was rejected.

Behaviour:
- Coefficient order within each section:
  - idx0 = -a1, default 25'h0007D71 (1.96)
  - idx1 = -a2, default 25'h1FFC287 (-0.9605)
  - idx2 = b0, default 25'h0000003
  - idx3 = b1, default 25'h0000007
  - idx4 = b2, default 25'h0000003
- Reset: both banks load the defaults in every section.
- Reset: all outputs and the FSM clear to 0/IDLE.
- Reset applies mid-sweep as well; the sweep is aborted and a pending swap is discarded.
- FSM states: IDLE, RUN.
- IDLE -> RUN when start=1 is sampled.
  - Next cycle: coef_valid=1, coef_sect=0, coef_idx=0, value read from the active bank. Latency is 1 cycle.
  - start while busy=1 is ignored, not queued.
- RUN handshake: a transfer occurs when coef_valid && coef_ready.
  - Without a transfer, coef_out/idx/sect/last hold stable.
  - On a transfer, coef_idx increments. Past 4 it wraps to 0 and coef_sect increments.
- coef_last=1 exactly when coef_sect=NUM_SECT-1 and coef_idx=4.
  - A transfer with coef_last=1 returns the FSM to IDLE.
  - In that case coef_valid, coef_last and busy drop to 0 in the next cycle.
- busy=1 in RUN only. Outputs are all registered.
- A full sweep takes NUM_SECT*5 transfers, minimum NUM_SECT*5 cycles.
- Writes:
  - cfg_we with cfg_idx<=4 and cfg_sect<NUM_SECT writes the shadow bank at the next edge, in any state.
  - Otherwise there is no write, and cfg_err=1 for the next cycle only.
- swap_req sets swap_pending. Repeated requests while pending are idempotent.
- The swap is applied in the first clock edge at which the FSM is IDLE.
  - This includes the edge of the final transfer's return, i.e. the first IDLE cycle after it.
  - When applied, all active entries <= shadow entries in one edge, and swap_pending clears.
- Same-edge rules:
  - The swap copy uses the shadow contents before a coincident cfg_we. The write lands in shadow only.
  - Swap applied and start sampled in the same IDLE cycle: the sweep reads the new active values.
  - swap_req arriving during RUN is applied after the sweep; the current sweep uses the old values throughout.
- Active bank is never written except by the swap.
- Shadow is never read by the sequencer.

Test Plan:
- Reset, then start with coef_ready=1, NUM_SECT=2 -> 10 consecutive valid cycles, values 0007D71, 1FFC287, 3, 7, 3 repeated. coef_last only on the 10th; busy drops the next cycle.
- Backpressure: coef_ready toggled 1,0,0,1,... -> outputs hold during ready=0, no skipped or duplicated indices, still exactly 10 transfers.
- Write sect1 idx2 = 25'h0000010, then start with no swap -> sweep shows 3 at sect1 idx2.
  - Then swap_req in IDLE, start -> shows 0000010; swap_pending goes 1 for one cycle, then 0.
- swap_req at transfer 4 of a sweep -> remainder of the sweep uses old values; swap_pending stays 1 until the first IDLE edge; the next sweep uses new values.
- cfg_we with cfg_idx=5, then with cfg_sect=3 at NUM_SECT=2 -> cfg_err pulses one cycle each; a following sweep after a swap is unchanged from defaults.
- Reset asserted at transfer 6, with swap_pending=1 and shadow modified -> next cycle busy=0, coef_valid=0, swap_pending=0; the next sweep returns default values.

Source files
------------

// File: rtl/coef_bank_biquad.sv
// Coefficient bank for cascaded biquads: shadow bank for writes, active bank streamed to the MAC.
// Latency: first coefficient valid 1 cycle after start; one coefficient per accepted transfer.
// Backpressure: outputs hold while coef_ready is low; swaps are deferred until the sequencer is idle.
module coef_bank_biquad #(
    parameter int W        = 25,
    parameter int NUM_SECT = 2,
    parameter int SECT_W   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              coef_ready,
    input  logic              cfg_we,
    input  logic [SECT_W-1:0] cfg_sect,
    input  logic [2:0]        cfg_idx,
    input  logic [W-1:0]      cfg_data,
    input  logic              swap_req,
    output logic [W-1:0]      coef_out,
    output logic [2:0]        coef_idx,
    output logic [SECT_W-1:0] coef_sect,
    output logic              coef_valid,
    output logic              coef_last,
    output logic              busy,
    output logic              swap_pending,
    output logic              cfg_err
);

    localparam int                NCOEF     = 5;
    localparam logic [SECT_W-1:0] LAST_SECT = SECT_W'(NUM_SECT - 1);
    localparam logic [2:0]        LAST_IDX  = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Reset value of each coefficient slot: -a1, -a2, b0, b1, b2 (Q10.14, sign-extended to W).
    function automatic logic [W-1:0] dflt(input int i);
        logic [24:0] v;
        case (i)
            0:       v = 25'h0007D71;
            1:       v = 25'h1FFC287;
            2:       v = 25'h0000003;
            3:       v = 25'h0000007;
            default: v = 25'h0000003;
        endcase
        return W'($signed(v));
    endfunction

    logic [W-1:0] shadow [NUM_SECT][NCOEF];
    logic [W-1:0] active [NUM_SECT][NCOEF];

    state_t            state;
    state_t            state_nxt;
    logic              xfer;
    logic              swap_now;
    logic              cfg_ok;
    logic              load;
    logic [SECT_W-1:0] rd_sect;
    logic [2:0]        rd_idx;
    logic [W-1:0]      rd_val;
    logic [SECT_W-1:0] sect_nxt;
    logic [2:0]        idx_nxt;
    logic              valid_nxt;
    logic              last_nxt;
    logic              busy_nxt;

    assign xfer     = coef_valid && coef_ready;
    // A pending swap lands on any edge where the sequencer sits in IDLE.
    assign swap_now = swap_pending && (state == IDLE);
    assign cfg_ok   = (cfg_idx <= LAST_IDX) && (int'(cfg_sect) < NUM_SECT);

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rd_sect   = '0;
        rd_idx    = '0;
        sect_nxt  = coef_sect;
        idx_nxt   = coef_idx;
        valid_nxt = coef_valid;
        last_nxt  = coef_last;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (coef_last) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        busy_nxt  = 1'b0;
                    end else begin
                        load = 1'b1;
                        if (coef_idx == LAST_IDX) begin
                            rd_sect = coef_sect + SECT_W'(1);
                            rd_idx  = 3'd0;
                        end else begin
                            rd_sect = coef_sect;
                            rd_idx  = coef_idx + 3'd1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            sect_nxt = rd_sect;
            idx_nxt  = rd_idx;
            last_nxt = (rd_sect == LAST_SECT) && (rd_idx == LAST_IDX);
        end
    end

    // Coefficient read mux; on a swap edge the shadow is the value about to become active.
    always_comb begin
        rd_val = '0;
        for (int s = 0; s < NUM_SECT; s++) begin
            for (int i = 0; i < NCOEF; i++) begin
                if (rd_sect == SECT_W'(s) && rd_idx == 3'(i)) begin
                    rd_val = swap_now ? shadow[s][i] : active[s][i];
                end
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            coef_out   <= '0;
            coef_idx   <= '0;
            coef_sect  <= '0;
            coef_valid <= 1'b0;
            coef_last  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (load) begin
                coef_out <= rd_val;
            end
            coef_idx   <= idx_nxt;
            coef_sect  <= sect_nxt;
            coef_valid <= valid_nxt;
            coef_last  <= last_nxt;
            busy       <= busy_nxt;
        end
    end

    // Banks: swap copies the pre-write shadow; a coincident write lands in shadow only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SECT; s++) begin
                for (int i = 0; i < NCOEF; i++) begin
                    shadow[s][i] <= dflt(i);
                    active[s][i] <= dflt(i);
                end
            end
        end else begin
            for (int s = 0; s < NUM_SECT; s++) begin
                for (int i = 0; i < NCOEF; i++) begin
                    if (swap_now) begin
                        active[s][i] <= shadow[s][i];
                    end
                    if (cfg_we && cfg_ok && cfg_sect == SECT_W'(s) && cfg_idx == 3'(i)) begin
                        shadow[s][i] <= cfg_data;
                    end
                end
            end
        end
    end

    // Swap request flag: set by any request, cleared when the copy is performed.
    always_ff @(posedge clk) begin
        if (reset) begin
            swap_pending <= 1'b0;
        end else if (swap_now) begin
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    // One-cycle error pulse for an out-of-range write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

endmodule

// File: tb/tb_coef_bank_biquad.sv
// Bench for coef_bank_biquad: randomized and directed sweeps checked against a scoreboard model.
// Model keeps shadow/active arrays and a queue of expected coefficients per sweep.
// Outputs are sampled on the falling edge; inputs change only after that sample.
module tb_coef_bank_biquad;

    localparam int W  = 25;
    localparam int NS = 2;
    localparam int SW = 2;

    localparam logic [W-1:0] DEF [5] = '{25'h0007D71, 25'h1FFC287, 25'h0000003,
                                         25'h0000007, 25'h0000003};

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          coef_ready;
    logic          cfg_we;
    logic [SW-1:0] cfg_sect;
    logic [2:0]    cfg_idx;
    logic [W-1:0]  cfg_data;
    logic          swap_req;
    logic [W-1:0]  coef_out;
    logic [2:0]    coef_idx;
    logic [SW-1:0] coef_sect;
    logic          coef_valid;
    logic          coef_last;
    logic          busy;
    logic          swap_pending;
    logic          cfg_err;

    coef_bank_biquad #(.W(W), .NUM_SECT(NS), .SECT_W(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .coef_ready(coef_ready),
        .cfg_we(cfg_we), .cfg_sect(cfg_sect), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .swap_req(swap_req), .coef_out(coef_out), .coef_idx(coef_idx),
        .coef_sect(coef_sect), .coef_valid(coef_valid), .coef_last(coef_last),
        .busy(busy), .swap_pending(swap_pending), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  val;
        logic [SW-1:0] sect;
        logic [2:0]    idx;
    } item_t;

    logic [W-1:0] m_sh  [NS][5];
    logic [W-1:0] m_act [NS][5];
    bit           m_pend;
    bit           m_err;
    item_t        q[$];
    int           npass = 0;
    int           ntot  = 0;
    int           nfail = 0;
    int           dut_x = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < 5; i++) begin
                m_sh[s][i]  = DEF[i];
                m_act[s][i] = DEF[i];
            end
        m_pend = 0;
        m_err  = 0;
        q.delete();
    endtask

    task automatic check_outputs();
        chk("busy", busy, q.size() != 0);
        chk("coef_valid", coef_valid, q.size() != 0);
        chk("swap_pending", swap_pending, m_pend);
        chk("cfg_err", cfg_err, m_err);
        if (q.size() != 0) begin
            chk("coef_out", coef_out, q[0].val);
            chk("coef_idx", coef_idx, q[0].idx);
            chk("coef_sect", coef_sect, q[0].sect);
            chk("coef_last", coef_last, q.size() == 1);
        end
    endtask

    // One clock: model advances on the rising edge, outputs are compared on the falling edge.
    task automatic step();
        bit applied;
        bit busy_pre;
        if (coef_valid && coef_ready) dut_x++;
        @(posedge clk);
        applied = 0;
        if (reset) begin
            model_reset();
        end else begin
            m_err    = cfg_we && !(cfg_idx <= 3'd4 && int'(cfg_sect) < NS);
            busy_pre = q.size() != 0;
            if (busy_pre) begin
                if (coef_ready) void'(q.pop_front());
            end else begin
                if (m_pend) begin
                    m_act   = m_sh;
                    m_pend  = 0;
                    applied = 1;
                end
                if (start) begin
                    for (int s = 0; s < NS; s++)
                        for (int i = 0; i < 5; i++)
                            q.push_back(item_t'{m_act[s][i], SW'(s), 3'(i)});
                end
            end
            if (swap_req && !applied) m_pend = 1;
            if (cfg_we && !m_err) m_sh[int'(cfg_sect)][int'(cfg_idx)] = cfg_data;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        start    = 0;
        swap_req = 0;
        cfg_we   = 0;
        cfg_sect = '0;
        cfg_idx  = '0;
        cfg_data = '0;
    endtask

    task automatic rand_cfg();
        cfg_we   = ($urandom_range(0, 3) == 0);
        cfg_sect = SW'($urandom_range(0, 3));
        cfg_idx  = 3'($urandom_range(0, 7));
        cfg_data = W'($urandom);
    endtask

    task automatic write(input int s, input int i, input logic [W-1:0] d);
        cfg_we   = 1;
        cfg_sect = SW'(s);
        cfg_idx  = 3'(i);
        cfg_data = d;
        step();
        idle_inputs();
    endtask

    // mode 0: always ready; 1: ready 1,0,0 repeating; 2: random ready, starts and writes.
    task automatic run_sweep(input int mode, input int swap_at, input int rst_at);
        int k;
        int done;
        dut_x      = 0;
        done       = 0;
        start      = 1;
        coef_ready = (mode == 0);
        step();
        start = 0;
        k = 1;
        while (q.size() != 0 && k < 200) begin
            coef_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 3) == 1)
                                                           : 1'($urandom_range(0, 1));
            if (coef_ready) done++;
            swap_req = (done == swap_at + 1) && coef_ready;
            reset    = (done == rst_at + 1) && coef_ready;
            if (mode == 2) begin
                start = ($urandom_range(0, 7) == 0);
                rand_cfg();
            end
            step();
            idle_inputs();
            reset = 0;
            k++;
        end
        chk("sweep_end_busy", busy, 0);
        if (rst_at < 0) chk("xfer_count", dut_x, NS * 5);
        step();
    endtask

    initial begin
        idle_inputs();
        coef_ready = 0;
        reset      = 1;
        model_reset();
        step();
        step();
        reset = 0;
        step();
        chk("rst_coef_out", coef_out, 0);
        chk("rst_coef_idx", coef_idx, 0);
        chk("rst_coef_sect", coef_sect, 0);
        chk("rst_coef_last", coef_last, 0);

        run_sweep(0, -1, -1);
        run_sweep(1, -1, -1);

        write(1, 2, 25'h0000010);
        run_sweep(0, -1, -1);
        swap_req = 1;
        step();
        swap_req = 0;
        step();
        run_sweep(0, -1, -1);

        write(0, 0, W'($urandom));
        run_sweep(1, 3, -1);
        run_sweep(0, -1, -1);

        write(1, 4, W'($urandom));
        swap_req = 1;
        step();
        swap_req = 0;
        run_sweep(0, -1, -1);

        write(0, 5, W'($urandom));
        write(3, 2, W'($urandom));
        step();
        swap_req = 1;
        step();
        swap_req = 0;
        step();
        run_sweep(0, -1, -1);

        write(0, 1, W'($urandom));
        write(1, 3, W'($urandom));
        run_sweep(0, 1, 5);
        run_sweep(0, -1, -1);

        for (int n = 0; n < 12; n++) begin
            for (int j = 0; j < 3; j++) begin
                rand_cfg();
                swap_req = ($urandom_range(0, 2) == 0);
                step();
                idle_inputs();
            end
            run_sweep(2, int'($urandom_range(0, 12)), -1);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
